// File: rtl/dsp_pkg.sv
// rtl/dsp_pkg.sv - shared constants and operand-select codes for the DSP post-adder slice
//
// Purpose : width constants and the X/Z operand-select encodings carried in
//           opmode[1:0] and opmode[3:2].
// Ports   : none (package).
package dsp_pkg;

  localparam int P_W = 48;
  localparam int M_W = 36;

  typedef enum logic [1:0] {
    X_ZERO = 2'd0,
    X_M    = 2'd1,
    X_P    = 2'd2,
    X_DAB  = 2'd3
  } x_sel_e;

  typedef enum logic [1:0] {
    Z_ZERO = 2'd0,
    Z_PCIN = 2'd1,
    Z_P    = 2'd2,
    Z_C    = 2'd3
  } z_sel_e;

endpackage

// File: rtl/dsp_stage_reg.sv
// rtl/dsp_stage_reg.sv - pipeline stage register with async reset, enable and bypass
//
// Purpose : one optional pipeline stage. REG=1 presents the register output,
//           REG=0 passes d straight through and the enable has no effect.
// Ports   : clk  - clock, rising edge
//           rst  - asynchronous active-high reset, clears the register
//           ce   - load enable
//           d    - stage input  [W-1:0]
//           q    - stage output [W-1:0]
module dsp_stage_reg #(
  parameter int W   = 1,
  parameter int REG = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_reg <= '0;
    end else if (ce) begin
      q_reg <= d;
    end
  end

  assign q = (REG != 0) ? q_reg : d;

endmodule

// File: rtl/dsp_post_adder_acc.sv
// rtl/dsp_post_adder_acc.sv - DSP48A1-style post-adder / accumulator stage
//
// Purpose : selects X and Z operands under opmode, adds or subtracts them with a
//           selectable carry-in and holds the result in the P accumulator.
// Optional: define PATTERN_DETECT_EN to add PATTERN/MASK parameters and the
//           registered patterndetect / patternbdetect outputs.
// Ports   : clk, rst          - clock (rising edge), async active-high reset
//           ceopmode          - OPMODE register enable
//           cecarryin         - carry-in register enable
//           cep               - P / carryout register enable
//           opmode[7:0]       - [1:0] X sel, [3:2] Z sel, [5] carry, [7] subtract
//           m_in[35:0]        - multiplier product
//           dab_in[47:0]      - {D[11:0], A[17:0], B[17:0]}
//           c_in[47:0]        - C operand
//           pcin[47:0]        - cascade input from previous slice
//           carryin           - external carry-in
//           patterndetect     - (optional) masked match of result against PATTERN
//           patternbdetect    - (optional) masked match against ~PATTERN
//           p, pcout[47:0]    - result and its cascade copy
//           carryout(f)       - adder carry / borrow and its copy
module dsp_post_adder_acc
  import dsp_pkg::*;
#(
`ifdef PATTERN_DETECT_EN
  parameter logic [47:0] PATTERN = 48'h0,
  parameter logic [47:0] MASK    = 48'h0,
`endif
  parameter int OPMODEREG   = 1,
  parameter int CARRYINREG  = 1,
  parameter int PREG        = 1,
  parameter int CARRYOUTREG = 1,
  parameter     CARRYINSEL  = "OPMODE5"
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ceopmode,
  input  logic           cecarryin,
  input  logic           cep,
  input  logic [7:0]     opmode,
  input  logic [M_W-1:0] m_in,
  input  logic [P_W-1:0] dab_in,
  input  logic [P_W-1:0] c_in,
  input  logic [P_W-1:0] pcin,
  input  logic           carryin,
`ifdef PATTERN_DETECT_EN
  output logic           patterndetect,
  output logic           patternbdetect,
`endif
  output logic [P_W-1:0] p,
  output logic [P_W-1:0] pcout,
  output logic           carryout,
  output logic           carryoutf
);

  logic [7:0]     opmode_q;
  logic           cin_src;
  logic           cin_q;
  logic [P_W-1:0] p_fb;
  logic [P_W-1:0] x_mux;
  logic [P_W-1:0] z_mux;
  logic [P_W:0]   addend;
  logic [P_W:0]   r;
  logic           co_q;

  // Carry source is taken from the raw opmode bit, so that both opmode_q and
  // cin_q reach the adder on the same edge when the stages are registered.
  generate
    if (CARRYINSEL == "OPMODE5") begin : g_cin_opmode5
      assign cin_src = opmode[5];
    end else if (CARRYINSEL == "CARRYIN") begin : g_cin_port
      assign cin_src = carryin;
    end else begin : g_cin_bad
      $error("dsp_post_adder_acc: CARRYINSEL must be \"OPMODE5\" or \"CARRYIN\"");
      assign cin_src = 1'b0;
    end
  endgenerate

  dsp_stage_reg #(.W(8), .REG(OPMODEREG)) u_opmode_reg (
    .clk (clk),
    .rst (rst),
    .ce  (ceopmode),
    .d   (opmode),
    .q   (opmode_q)
  );

  dsp_stage_reg #(.W(1), .REG(CARRYINREG)) u_cyi_reg (
    .clk (clk),
    .rst (rst),
    .ce  (cecarryin),
    .d   (cin_src),
    .q   (cin_q)
  );

  always_comb begin
    x_mux = '0;
    case (x_sel_e'(opmode_q[1:0]))
      X_ZERO: x_mux = '0;
      X_M:    x_mux = {{(P_W-M_W){1'b0}}, m_in};
      X_P:    x_mux = p_fb;
      X_DAB:  x_mux = dab_in;
      default: x_mux = '0;
    endcase
  end

  always_comb begin
    z_mux = '0;
    case (z_sel_e'(opmode_q[3:2]))
      Z_ZERO: z_mux = '0;
      Z_PCIN: z_mux = pcin;
      Z_P:    z_mux = p_fb;
      Z_C:    z_mux = c_in;
      default: z_mux = '0;
    endcase
  end

  // 49-bit arithmetic: bit 48 is the carry on add and the borrow on subtract.
  always_comb begin
    addend = {1'b0, x_mux} + {{P_W{1'b0}}, cin_q};
    if (opmode_q[7]) begin
      r = {1'b0, z_mux} - addend;
    end else begin
      r = {1'b0, z_mux} + addend;
    end
  end

  // The accumulator register always exists: feedback must come from a flop
  // even when the p output itself is bypassed, which rules out a comb loop.
  dsp_stage_reg #(.W(P_W), .REG(1)) u_p_reg (
    .clk (clk),
    .rst (rst),
    .ce  (cep),
    .d   (r[P_W-1:0]),
    .q   (p_fb)
  );

  dsp_stage_reg #(.W(1), .REG(((PREG != 0) && (CARRYOUTREG != 0)) ? 1 : 0)) u_carryout_reg (
    .clk (clk),
    .rst (rst),
    .ce  (cep),
    .d   (r[P_W]),
    .q   (co_q)
  );

  assign p         = (PREG != 0) ? p_fb : r[P_W-1:0];
  assign pcout     = p;
  assign carryout  = co_q;
  assign carryoutf = co_q;

`ifdef PATTERN_DETECT_EN
  logic [1:0] pat_q;
  logic       pd_comb;
  logic       pbd_comb;

  assign pd_comb  = (((r[P_W-1:0] ^ PATTERN) & ~MASK) == '0);
  assign pbd_comb = (((r[P_W-1:0] ^ ~PATTERN) & ~MASK) == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pat_q <= '0;
    end else if (cep) begin
      pat_q <= {pd_comb, pbd_comb};
    end
  end

  assign patterndetect  = pat_q[1];
  assign patternbdetect = pat_q[0];
`endif

  // Bits with no function in this slice (and the carry source not selected).
  logic unused_ok;
  assign unused_ok = &{1'b0, carryin, opmode[6], opmode[5], opmode[4],
                       opmode_q[6], opmode_q[5], opmode_q[4]};

endmodule

// File: tb/tb_dsp_post_adder_acc.sv
// tb/tb_dsp_post_adder_acc.sv - scoreboard bench for dsp_post_adder_acc
module tb_dsp_post_adder_acc;

  logic        clk;
  logic        rst;
  logic        ceopmode;
  logic        cecarryin;
  logic        cep;
  logic [7:0]  opmode;
  logic [35:0] m_in;
  logic [47:0] dab_in;
  logic [47:0] c_in;
  logic [47:0] pcin;
  logic        carryin;

  logic [47:0] p_a, pcout_a, p_b, pcout_b;
  logic        co_a, cof_a, co_b, cof_b;
`ifdef PATTERN_DETECT_EN
  logic        pd_a, pbd_a, pd_b, pbd_b;
`endif

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int          due;
    logic [47:0] p;
    logic        co;
    string       tag;
  } exp_t;

  exp_t sb[$];

  dsp_post_adder_acc u_dut_a (
    .clk       (clk),
    .rst       (rst),
    .ceopmode  (ceopmode),
    .cecarryin (cecarryin),
    .cep       (cep),
    .opmode    (opmode),
    .m_in      (m_in),
    .dab_in    (dab_in),
    .c_in      (c_in),
    .pcin      (pcin),
    .carryin   (carryin),
`ifdef PATTERN_DETECT_EN
    .patterndetect  (pd_a),
    .patternbdetect (pbd_a),
`endif
    .p         (p_a),
    .pcout     (pcout_a),
    .carryout  (co_a),
    .carryoutf (cof_a)
  );

  dsp_post_adder_acc #(
    .OPMODEREG   (0),
    .CARRYINREG  (0),
    .PREG        (0),
    .CARRYOUTREG (0),
    .CARRYINSEL  ("CARRYIN")
  ) u_dut_b (
    .clk       (clk),
    .rst       (rst),
    .ceopmode  (ceopmode),
    .cecarryin (cecarryin),
    .cep       (cep),
    .opmode    (opmode),
    .m_in      (m_in),
    .dab_in    (dab_in),
    .c_in      (c_in),
    .pcin      (pcin),
    .carryin   (carryin),
`ifdef PATTERN_DETECT_EN
    .patterndetect  (pd_b),
    .patternbdetect (pbd_b),
`endif
    .p         (p_b),
    .pcout     (pcout_b),
    .carryout  (co_b),
    .carryoutf (cof_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input int ofs, input logic [47:0] pv, input logic cov, input string tag);
    exp_t e;
    e.due = cyc + ofs;
    e.p   = pv;
    e.co  = cov;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    cyc++;
    #1;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      chk({e.tag, "_p"}, p_a, e.p);
      chk({e.tag, "_co"}, co_a, e.co);
      chk({e.tag, "_pcout"}, pcout_a, e.p);
      chk({e.tag, "_cof"}, cof_a, e.co);
    end
  endtask

  initial begin
    logic [63:0] r1, r2;
    logic [48:0] s;

    rst       = 1'b1;
    ceopmode  = 1'b1;
    cecarryin = 1'b1;
    cep       = 1'b1;
    opmode    = 8'h00;
    m_in      = '0;
    dab_in    = '0;
    c_in      = '0;
    pcin      = '0;
    carryin   = 1'b0;

    #2;
    chk("rst_p", p_a, 48'h0);
    chk("rst_pcout", pcout_a, 48'h0);
    chk("rst_co", co_a, 1'b0);
    chk("rst_cof", cof_a, 1'b0);
    tick();
    tick();

    // Load p = 0x123: opmode registered -> two edges.
    rst    = 1'b0;
    opmode = 8'h0F;
    dab_in = 48'h123;
    c_in   = 48'h0;
    push(2, 48'h123, 1'b0, "load");
    tick();
    tick();

    // Asynchronous reset pulse in mid-cycle.
    #3;
    rst = 1'b1;
    #1;
    chk("arst_p", p_a, 48'h0);
    chk("arst_co", co_a, 1'b0);
    tick();
    chk("arst_hold_p", p_a, 48'h0);

    // MAC accumulation restarts from 0 after reset.
    rst    = 1'b0;
    opmode = 8'h09;
    m_in   = 36'd100;
    push(1, 48'd0,   1'b0, "mac0");
    push(2, 48'd100, 1'b0, "mac1");
    push(3, 48'd200, 1'b0, "mac2");
    push(4, 48'd300, 1'b0, "mac3");
    repeat (4) tick();

    // Enable hold.
    cep  = 1'b0;
    m_in = 36'd5;
    push(1, 48'd300, 1'b0, "hold1");
    tick();
    m_in = 36'd9;
    push(1, 48'd300, 1'b0, "hold2");
    tick();
    cep = 1'b1;
    push(1, 48'd309, 1'b0, "resume1");
    push(2, 48'd318, 1'b0, "resume2");
    tick();
    tick();

    // Subtract with borrow.
    opmode = 8'h85;
    pcin   = 48'd5;
    m_in   = 36'd7;
    push(2, 48'hFFFF_FFFF_FFFE, 1'b1, "sub");
    tick();
    tick();

    // Wrap-around, then with carry-in from opmode[5].
    opmode = 8'h0F;
    dab_in = 48'hFFFF_FFFF_FFFF;
    c_in   = 48'd1;
    push(2, 48'h0, 1'b1, "wrap");
    tick();
    tick();
    opmode = 8'h2F;
    push(1, 48'h0, 1'b1, "wrap_lat");
    push(2, 48'h1, 1'b1, "wrap_cin");
    tick();
    tick();

    // Random C + D:A:B, opmode held steady.
    opmode = 8'h0F;
    tick();
    for (int i = 0; i < 20; i++) begin
      r1 = {$urandom(), $urandom()};
      r2 = {$urandom(), $urandom()};
      dab_in = r1[47:0];
      c_in   = r2[47:0];
      s = {1'b0, r1[47:0]} + {1'b0, r2[47:0]};
      push(1, s[47:0], s[48], "rand");
      tick();
    end

    // Fully bypassed instance: combinational, no clock edge between checks.
    #2;
    opmode  = 8'h0F;
    dab_in  = 48'd3;
    c_in    = 48'd4;
    carryin = 1'b0;
    #1;
    chk("byp_add_p", p_b, 48'd7);
    chk("byp_add_pcout", pcout_b, 48'd7);
    chk("byp_add_co", co_b, 1'b0);
    carryin = 1'b1;
    #1;
    chk("byp_cin_p", p_b, 48'd8);
    opmode  = 8'h8F;
    carryin = 1'b0;
    #1;
    chk("byp_sub_p", p_b, 48'd1);
    chk("byp_sub_co", co_b, 1'b0);
    c_in = 48'd1;
    #1;
    chk("byp_borrow_p", p_b, 48'hFFFF_FFFF_FFFE);
    chk("byp_borrow_cof", cof_b, 1'b1);

    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dsp_post_adder_acc.md
Name: dsp_post_adder_acc

Overview:
- Post-adder/accumulator stage of the DSP48A1-style slice.
- Sits directly downstream of the M (multiplier) pipeline register and the D:A:B concatenation path.
- Selects X and Z operands under OPMODE, adds or subtracts with a selectable carry-in, and holds the result in the P accumulator register.
- Drives p, pcout and carry-out to the next slice and to fabric.

Parameters:
- OPMODEREG, 1: 1 = OPMODE registered (CEOPMODE), 0 = combinational.
- CARRYINREG, 1: 1 = carry-in registered (CECARRYIN), 0 = combinational.
- PREG, 1: 1 = p/carryout taken from registers, 0 = combinational result.
- CARRYOUTREG, 1: 1 = carryout registered with P, 0 = combinational.
- CARRYINSEL, "OPMODE5": "OPMODE5" = cin from opmode[5]; "CARRYIN" = cin from the carryin port; any other value is an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all internal registers.
- ceopmode  in  1  OPMODE register enable.
- cecarryin  in  1  carry-in register enable.
- cep  in  1  P and carryout register enable.
- opmode  in  8  [1:0] X select, [3:2] Z select, [5] carry bit, [7] subtract.
- m_in  in  36  product from the M stage.
- dab_in  in  48  {D[11:0], A[17:0], B[17:0]}.
- c_in  in  48  C operand, already registered upstream.
- pcin  in  48  cascade input from the previous slice.
- carryin  in  1  external carry-in.
- p  out  48  result.
- pcout  out  48  copy of p.
- carryout  out  1  adder carry/borrow.
- carryoutf  out  1  copy of carryout.

Behaviour:
- Reset: all registers go to 0 immediately on rst=1, without waiting for a clock edge. With all REG parameters at 1, p=0, pcout=0, carryout=0 and carryoutf=0 while rst is high. rst has priority over every clock enable.
- Registers and enables:
  - Every register loads only when its enable is 1; otherwise it holds.
  - When a REG parameter is 0, that register is bypassed and its enable is ignored.
- X mux (opmode[1:0]):
  - 0: 0
  - 1: zero-extended m_in
  - 2: P feedback
  - 3: dab_in
- Z mux (opmode[3:2]):
  - 0: 0
  - 1: pcin
  - 2: P feedback
  - 3: c_in
- P feedback always comes from the internal P register output, even when PREG=0. No combinational loop is possible.
- Carry-in source: opmode[5] or carryin, per CARRYINSEL, optionally through the CYI register.
- Arithmetic, computed in 49 bits:
  - opmode[7]=0: R = Z + X + cin
  - opmode[7]=1: R = Z − (X + cin)
  - p = R[47:0]; carryout = R[48].
  - Wrap-around is modulo 2^48. No saturation.
- Latency:
  - All registers enabled, OPMODEREG=1: a new opmode affects p two edges after it is presented; data operands affect p one edge after they are presented.
  - All registers bypassed: p is combinational.
- Simultaneous events: an opmode change and a data change at the same edge apply per the latency above. There is no cross-field hazard handling; the bench must respect the latency.
- Reset during accumulation: the accumulator restarts from 0 at the first enabled edge after rst deasserts.

Optional Feature:
- Macro: PATTERN_DETECT_EN.
- Defined:
  - Adds parameters PATTERN (48'h0) and MASK (48'h0).
  - Adds outputs patterndetect and patternbdetect, 1 bit each, registered with P (cep) and reset to 0.
  - patterndetect = ((R[47:0] ^ PATTERN) & ~MASK) == 0.
  - patternbdetect = ((R[47:0] ^ ~PATTERN) & ~MASK) == 0.
- Undefined: neither the ports nor the logic exist.

Decomposition:
- Shared package dsp_pkg holds:
  - X-select codes: X_ZERO, X_M, X_P, X_DAB.
  - Z-select codes: Z_ZERO, Z_PCIN, Z_P, Z_C.
  - Width constants: P_W=48, M_W=36.
- One sub-module, dsp_stage_reg: a parameterised-width register with async reset, clock enable and a REG bypass parameter. It is instantiated four times: OPMODE, CYI, P and CARRYOUT.

Test Plan:
- Async reset: after p=48'h123 is loaded, pulse rst mid-cycle -> p=0 and carryout=0 before the next clk edge; the register holds 0 while rst is high.
- MAC: opmode=8'h09 (X=M, Z=P), m_in=100, all enables 1, reset released -> p=100, 200, 300 on successive edges after the OPMODE latency.
- Subtract: opmode=8'h85 (sub, Z=pcin, X=M), pcin=5, m_in=7, cin=0 -> p=48'hFFFF_FFFF_FFFE, carryout=1.
- Wrap: opmode=8'h0F, dab_in=48'hFFFF_FFFF_FFFF, c_in=1 -> p=0, carryout=1; with opmode=8'h2F (cin=1) -> p=1, carryout=1.
- Enable hold: cep=0 while m_in changes 5→9 under the MAC opmode -> p and carryout are unchanged; cep=1 resumes accumulation.
- Bypass: PREG=0, CARRYOUTREG=0, opmode=8'h0F, dab_in=3, c_in=4 -> p=7 in the same cycle with no clock edge.
